// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types for the iBus/dBus memory arbiter
package riscv_mem_pkg;

   localparam int MASK_W = 4;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      LOCK_I = 2'd1,
      LOCK_D = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_tag_fifo.sv
// rtl/mem_tag_fifo.sv - in-order owner-tag FIFO for outstanding memory reads
module mem_tag_fifo
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_push,
   input  owner_e i_push_owner,
   input  logic   i_pop,
   output logic   o_full,
   output logic   o_empty,
   output owner_e o_head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = owner_e'(r_mem[r_rd_ptr]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_owner;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one single-port memory between iBus and dBus
// dBus has priority; iBus is forced through after STARVE_LIMIT lost cycles.
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W       = 15,
   parameter int MAX_OUT      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cmd_valid,
   output logic              i_cmd_ready,
   input  logic [ADDR_W-1:0] i_cmd_pc,
   output logic              i_rsp_valid,
   output logic [31:0]       i_rsp_instr,
   input  logic              d_cmd_valid,
   output logic              d_cmd_ready,
   input  logic              d_cmd_wr,
   input  logic [ADDR_W-1:0] d_cmd_addr,
   input  logic [31:0]       d_cmd_data,
   input  logic [MASK_W-1:0] d_cmd_mask,
   output logic              d_rsp_valid,
   output logic [31:0]       d_rsp_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_data,
   output logic [MASK_W-1:0] m_mask,
   input  logic              m_rsp_valid,
   input  logic [31:0]       m_rsp_data,
   output logic              err_rsp
);

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   arb_state_e      r_state;
   arb_state_e      w_state_nxt;
   logic [SC_W-1:0] r_starve_cnt;
   logic            r_err;
   logic            w_full;
   logic            w_empty;
   owner_e          w_head;
   owner_e          w_push_owner;
   logic            w_push;
   logic            w_i_ok;
   logic            w_d_ok;
   logic            w_gnt_i;
   logic            w_gnt_d;

   // Reads need a free tag slot; writes return nothing and bypass the gate.
   assign w_i_ok = i_cmd_valid & ~w_full;
   assign w_d_ok = d_cmd_valid & (d_cmd_wr | ~w_full);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ARB;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ARB: begin
            if (w_gnt_i & ~m_ready) begin
               w_state_nxt = LOCK_I;
            end else if (w_gnt_d & ~m_ready) begin
               w_state_nxt = LOCK_D;
            end
         end
         LOCK_I, LOCK_D: begin
            if (m_valid & m_ready) begin
               w_state_nxt = ARB;
            end
         end
         default: w_state_nxt = ARB;
      endcase
   end

   // Grant is forced off during reset so every command output reads 0.
   always_comb begin
      w_gnt_i = 1'b0;
      w_gnt_d = 1'b0;
      if (!rst) begin
         case (r_state)
            LOCK_I: w_gnt_i = w_i_ok;
            LOCK_D: w_gnt_d = w_d_ok;
            default: begin
               if ((r_starve_cnt == SC_W'(STARVE_LIMIT)) && w_i_ok) begin
                  w_gnt_i = 1'b1;
               end else if (w_d_ok) begin
                  w_gnt_d = 1'b1;
               end else begin
                  w_gnt_i = w_i_ok;
               end
            end
         endcase
      end
   end

   assign m_valid     = w_gnt_i | w_gnt_d;
   assign m_we        = w_gnt_d & d_cmd_wr;
   assign m_addr      = w_gnt_d ? d_cmd_addr : (w_gnt_i ? i_cmd_pc : '0);
   assign m_data      = w_gnt_d ? d_cmd_data : '0;
   assign m_mask      = w_gnt_d ? d_cmd_mask : '0;
   assign i_cmd_ready = w_gnt_i & m_ready;
   assign d_cmd_ready = w_gnt_d & m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (i_cmd_ready) begin
         r_starve_cnt <= '0;
      end else if (i_cmd_valid && w_gnt_d && (r_starve_cnt != SC_W'(STARVE_LIMIT))) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   assign w_push       = i_cmd_ready | (d_cmd_ready & ~d_cmd_wr);
   assign w_push_owner = i_cmd_ready ? OWN_I : OWN_D;

   mem_tag_fifo #(
      .DEPTH (MAX_OUT)
   ) u_tag_fifo (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_owner (w_push_owner),
      .i_pop        (m_rsp_valid),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_head       (w_head)
   );

   assign i_rsp_valid = m_rsp_valid & ~w_empty & (w_head == OWN_I);
   assign d_rsp_valid = m_rsp_valid & ~w_empty & (w_head == OWN_D);
   assign i_rsp_instr = m_rsp_data;
   assign d_rsp_data  = m_rsp_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (m_rsp_valid & w_empty) begin
         r_err <= 1'b1;
      end
   end

   assign err_rsp = r_err;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

   localparam int ADDR_W = 15;
   localparam int MAX_OUT = 2;
   localparam int LIMIT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_cmd_valid = 1'b0;
   logic              i_cmd_ready;
   logic [ADDR_W-1:0] i_cmd_pc = '0;
   logic              i_rsp_valid;
   logic [31:0]       i_rsp_instr;
   logic              d_cmd_valid = 1'b0;
   logic              d_cmd_ready;
   logic              d_cmd_wr = 1'b0;
   logic [ADDR_W-1:0] d_cmd_addr = '0;
   logic [31:0]       d_cmd_data = '0;
   logic [3:0]        d_cmd_mask = '0;
   logic              d_rsp_valid;
   logic [31:0]       d_rsp_data;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_data;
   logic [3:0]        m_mask;
   logic              m_rsp_valid = 1'b0;
   logic [31:0]       m_rsp_data = '0;
   logic              err_rsp;

   always #5 clk = ~clk;

   riscv_mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .MAX_OUT      (MAX_OUT),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_cmd_valid (i_cmd_valid),
      .i_cmd_ready (i_cmd_ready),
      .i_cmd_pc    (i_cmd_pc),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_instr (i_rsp_instr),
      .d_cmd_valid (d_cmd_valid),
      .d_cmd_ready (d_cmd_ready),
      .d_cmd_wr    (d_cmd_wr),
      .d_cmd_addr  (d_cmd_addr),
      .d_cmd_data  (d_cmd_data),
      .d_cmd_mask  (d_cmd_mask),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_data  (d_rsp_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_we        (m_we),
      .m_addr      (m_addr),
      .m_data      (m_data),
      .m_mask      (m_mask),
      .m_rsp_valid (m_rsp_valid),
      .m_rsp_data  (m_rsp_data),
      .err_rsp     (err_rsp)
   );

   int n_checks = 0;
   int n_pass = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endfunction

   function automatic void check_str(string name, string act, string exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %s expected %s", name, act, exp);
   endfunction

   // Model: owner queue (1=I, 2=D), bus currently held (0 none), starve count, error flag.
   int own_q[$];
   int own_q_n[$];
   int held = 0;
   int held_n = 0;
   int starve = 0;
   int starve_n = 0;
   bit err_m = 1'b0;
   bit err_n = 1'b0;

   always @(negedge clk) begin : cmp_proc
      bit          full;
      bit          i_ok;
      bit          d_ok;
      bit          mv;
      int          who;
      logic [31:0] e_addr;
      if (rst) begin
         check("rst m_valid", m_valid, 0);
         check("rst i_cmd_ready", i_cmd_ready, 0);
         check("rst d_cmd_ready", d_cmd_ready, 0);
         check("rst m_addr", m_addr, 0);
         check("rst m_data", m_data, 0);
         check("rst m_mask", m_mask, 0);
         check("rst i_rsp_valid", i_rsp_valid, 0);
         check("rst d_rsp_valid", d_rsp_valid, 0);
         check("rst err_rsp", err_rsp, 0);
         own_q_n = {};
         held_n = 0;
         starve_n = 0;
         err_n = 1'b0;
      end else begin
         full = own_q.size() >= MAX_OUT;
         i_ok = i_cmd_valid && !full;
         d_ok = d_cmd_valid && (d_cmd_wr || !full);
         if (held == 1) who = i_ok ? 1 : 0;
         else if (held == 2) who = d_ok ? 2 : 0;
         else if (starve == LIMIT && i_ok) who = 1;
         else if (d_ok) who = 2;
         else if (i_ok) who = 1;
         else who = 0;
         mv = (who != 0);
         e_addr = (who == 2) ? 32'(d_cmd_addr) : ((who == 1) ? 32'(i_cmd_pc) : 32'h0);
         check("m_valid", m_valid, mv);
         check("m_we", m_we, (who == 2) && d_cmd_wr);
         check("m_addr", m_addr, e_addr);
         check("m_data", m_data, (who == 2) ? d_cmd_data : 32'h0);
         check("m_mask", m_mask, (who == 2) ? 32'(d_cmd_mask) : 32'h0);
         check("i_cmd_ready", i_cmd_ready, (who == 1) && m_ready);
         check("d_cmd_ready", d_cmd_ready, (who == 2) && m_ready);
         check("i_rsp_valid", i_rsp_valid, m_rsp_valid && own_q.size() > 0 && own_q[0] == 1);
         check("d_rsp_valid", d_rsp_valid, m_rsp_valid && own_q.size() > 0 && own_q[0] == 2);
         check("i_rsp_instr", i_rsp_instr, m_rsp_data);
         check("d_rsp_data", d_rsp_data, m_rsp_data);
         check("err_rsp", err_rsp, err_m);
         own_q_n = own_q;
         err_n = err_m;
         if (m_rsp_valid) begin
            if (own_q_n.size() > 0) void'(own_q_n.pop_front());
            else err_n = 1'b1;
         end
         if (mv && m_ready && !(who == 2 && d_cmd_wr)) own_q_n.push_back(who);
         held_n = held;
         if (mv) held_n = m_ready ? 0 : who;
         starve_n = starve;
         if (who == 1 && m_ready) starve_n = 0;
         else if (who == 2 && i_cmd_valid && starve < LIMIT) starve_n = starve + 1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         own_q = {};
         held = 0;
         starve = 0;
         err_m = 1'b0;
      end else begin
         own_q = own_q_n;
         held = held_n;
         starve = starve_n;
         err_m = err_n;
      end
   end

   logic [31:0]       mem [0:63];
   bit                auto_rsp = 1'b1;
   logic              s_i_rdy, s_d_rdy, s_mv, s_we, s_mr;
   logic [ADDR_W-1:0] s_addr;
   logic [31:0]       s_data;
   logic [3:0]        s_mask;
   logic [31:0]       i_got[$];
   logic [31:0]       d_got[$];
   string             glog;

   // One clock: snapshot mid-cycle, then act as a 1-cycle-latency memory.
   task automatic step();
      @(negedge clk);
      s_i_rdy = i_cmd_ready;
      s_d_rdy = d_cmd_ready;
      s_mv = m_valid;
      s_we = m_we;
      s_mr = m_ready;
      s_addr = m_addr;
      s_data = m_data;
      s_mask = m_mask;
      if (i_rsp_valid) i_got.push_back(i_rsp_instr);
      if (d_rsp_valid) d_got.push_back(d_rsp_data);
      if (s_i_rdy) glog = {glog, "I"};
      else if (s_d_rdy) glog = {glog, "D"};
      else glog = {glog, "-"};
      @(posedge clk);
      #1;
      if (s_mv && s_mr && s_we) begin
         for (int b = 0; b < 4; b++)
            if (s_mask[b]) mem[s_addr[7:2]][8*b +: 8] = s_data[8*b +: 8];
      end
      if (auto_rsp) begin
         m_rsp_valid = s_mv && s_mr && !s_we;
         m_rsp_data = m_rsp_valid ? mem[s_addr[7:2]] : 32'h0;
      end
   endtask

   initial begin
      int n;
      int guard;
      for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 + 32'(k);
      repeat (2) @(posedge clk);
      #1;
      check("reset m_valid", m_valid, 0);
      check("reset err_rsp", err_rsp, 0);
      rst = 1'b0;
      m_ready = 1'b1;

      // iBus alone, back-to-back fetches
      i_got = {};
      d_got = {};
      i_cmd_valid = 1'b1;
      n = 0;
      guard = 0;
      while (n < 3 && guard < 20) begin
         i_cmd_pc = 15'(4 * n);
         step();
         guard++;
         if (s_i_rdy) n++;
      end
      i_cmd_valid = 1'b0;
      step();
      step();
      check("t1 fetch cycles", guard, 3);
      check("t1 i rsp count", i_got.size(), 3);
      for (int k = 0; k < 3; k++)
         check("t1 instr", (k < i_got.size()) ? i_got[k] : 32'hx, 32'hA000_0000 + 32'(k));
      check("t1 d rsp count", d_got.size(), 0);

      // Both requesting every cycle: starvation counter forces iBus every fifth grant
      d_cmd_wr = 1'b1;
      d_cmd_addr = 15'h080;
      d_cmd_data = 32'h1234_5678;
      d_cmd_mask = 4'hF;
      d_cmd_valid = 1'b1;
      i_cmd_valid = 1'b1;
      i_cmd_pc = 15'h000;
      glog = "";
      repeat (10) step();
      check_str("t2 grants", glog, "DDDDIDDDDI");
      d_cmd_valid = 1'b0;
      i_cmd_valid = 1'b0;
      step();
      step();

      // Stalled dBus write keeps m_* stable
      d_got = {};
      i_got = {};
      d_cmd_addr = 15'h084;
      d_cmd_data = 32'hDEAD_BEEF;
      d_cmd_mask = 4'hC;
      d_cmd_valid = 1'b1;
      m_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t3 stall m_valid", s_mv, 1);
         check("t3 stall m_we", s_we, 1);
         check("t3 stall m_addr", s_addr, 32'h084);
         check("t3 stall m_data", s_data, 32'hDEAD_BEEF);
         check("t3 stall m_mask", s_mask, 32'hC);
         check("t3 stall d ready", s_d_rdy, 0);
      end
      m_ready = 1'b1;
      step();
      check("t3 accept", s_d_rdy, 1);
      d_cmd_valid = 1'b0;
      step();
      check("t3 no rsp", d_got.size() + i_got.size(), 0);
      check("t3 masked write", mem[33], 32'hDEAD_0021);

      // Tag FIFO full: reads blocked, writes pass
      auto_rsp = 1'b0;
      m_rsp_valid = 1'b0;
      i_got = {};
      d_got = {};
      d_cmd_wr = 1'b0;
      d_cmd_addr = 15'h000;
      d_cmd_valid = 1'b1;
      step();
      check("t4 d read acc", s_d_rdy, 1);
      d_cmd_valid = 1'b0;
      i_cmd_valid = 1'b1;
      i_cmd_pc = 15'h008;
      step();
      check("t4 i read acc", s_i_rdy, 1);
      i_cmd_pc = 15'h00C;
      d_cmd_wr = 1'b1;
      d_cmd_addr = 15'h088;
      d_cmd_data = 32'hCAFE_0000;
      d_cmd_mask = 4'hF;
      d_cmd_valid = 1'b1;
      step();
      check("t4 full i blocked", s_i_rdy, 0);
      check("t4 write passes", s_d_rdy, 1);
      d_cmd_valid = 1'b0;
      step();
      check("t4 still blocked", s_i_rdy, 0);
      m_rsp_valid = 1'b1;
      m_rsp_data = 32'h55;
      step();
      check("t4 blocked on pop", s_i_rdy, 0);
      check("t4 d rsp", (d_got.size() == 1) ? d_got[0] : 32'hx, 32'h55);
      m_rsp_valid = 1'b0;
      step();
      check("t4 accepted after pop", s_i_rdy, 1);
      i_cmd_valid = 1'b0;
      m_rsp_valid = 1'b1;
      m_rsp_data = 32'h66;
      step();
      m_rsp_data = 32'h77;
      step();
      m_rsp_valid = 1'b0;
      step();
      check("t4 i rsp count", i_got.size(), 2);
      check("t4 i rsp 0", (i_got.size() > 0) ? i_got[0] : 32'hx, 32'h66);
      check("t4 i rsp 1", (i_got.size() > 1) ? i_got[1] : 32'hx, 32'h77);
      check("t4 no err", err_rsp, 0);

      // I-read then D-read route back in order
      auto_rsp = 1'b1;
      mem[4] = 32'h11;
      mem[5] = 32'h22;
      i_got = {};
      d_got = {};
      i_cmd_valid = 1'b1;
      i_cmd_pc = 15'h010;
      step();
      i_cmd_valid = 1'b0;
      d_cmd_wr = 1'b0;
      d_cmd_addr = 15'h014;
      d_cmd_valid = 1'b1;
      step();
      d_cmd_valid = 1'b0;
      step();
      step();
      check("t5 i rsp", (i_got.size() == 1) ? i_got[0] : 32'hx, 32'h11);
      check("t5 d rsp", (d_got.size() == 1) ? d_got[0] : 32'hx, 32'h22);

      // Spurious response, then reset in the middle of a stall
      auto_rsp = 1'b0;
      i_got = {};
      d_got = {};
      m_rsp_valid = 1'b1;
      m_rsp_data = 32'h0;
      step();
      check("t6 no rsp routed", i_got.size() + d_got.size(), 0);
      m_rsp_valid = 1'b0;
      step();
      check("t6 err set", err_rsp, 1);
      step();
      check("t6 err sticky", err_rsp, 1);
      d_cmd_wr = 1'b1;
      d_cmd_addr = 15'h090;
      d_cmd_valid = 1'b1;
      m_ready = 1'b0;
      step();
      check("t6 stalled", s_mv, 1);
      rst = 1'b1;
      #2;
      check("t6 rst m_valid", m_valid, 0);
      check("t6 rst m_addr", m_addr, 0);
      check("t6 rst d ready", d_cmd_ready, 0);
      check("t6 rst err", err_rsp, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      d_cmd_valid = 1'b0;
      i_cmd_valid = 1'b1;
      i_cmd_pc = 15'h020;
      m_ready = 1'b1;
      step();
      check("t6 arb after rst", s_i_rdy, 1);
      i_cmd_valid = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
